clk_en_sched: RTL and testbench

//  Multi-channel clock-enable scheduler: one fast clock, NCH independent

---
 rtl/clk_sched_pkg.sv | 19 +
 rtl/clk_sched_chan.sv | 65 ++++++
 rtl/clk_en_sched.sv | 91 +++++++++
 tb/tb_clk_en_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sched_pkg.sv
// Shared types for the clock-enable scheduler: FSM state and the latched config request.
// Struct fields are sized for the largest supported top-level parameters (CHW <= 8, DW <= 32).
package clk_sched_pkg;

    localparam int unsigned SchedMaxChW = 8;
    localparam int unsigned SchedMaxDw  = 32;

    typedef enum logic [0:0] {
        IDLE,
        PEND
    } sched_state_t;

    typedef struct packed {
        logic [SchedMaxChW-1:0] ch;
        logic [SchedMaxDw-1:0]  div;
        logic                   en;
    } sched_cfg_t;

endpackage

// File: rtl/clk_sched_chan.sv
// One enable channel: wrap counter, registered ce/phase strobes and a boundary flag.
// A load pulse replaces div/active and restarts the period at cnt=0.
module clk_sched_chan #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] div_i,
    input  logic          en_i,
    output logic          ce_o,
    output logic          phase_o,
    output logic          active_o,
    output logic          boundary_o
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          active_q, active_d;
    logic          ce_q, ce_d;
    logic          phase_q, phase_d;
    logic          last;
    logic [DW:0]   half;

    always_comb begin
        last     = (cnt_q == div_q - {{(DW-1){1'b0}}, 1'b1});
        active_d = active_q;
        div_d    = div_q;
        if (load_i) begin
            active_d = en_i;
            div_d    = div_i;
        end
        if (load_i || !active_q || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end
        // ce/phase are computed from next-state so they line up with cnt_q
        half    = ({1'b0, div_d} + {{DW{1'b0}}, 1'b1}) >> 1;
        ce_d    = active_d && (cnt_d == '0);
        phase_d = active_d && ({1'b0, cnt_d} < half);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= {{(DW-1){1'b0}}, 1'b1};
            active_q <= 1'b0;
            ce_q     <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            active_q <= active_d;
            ce_q     <= ce_d;
            phase_q  <= phase_d;
        end
    end

    assign ce_o       = ce_q;
    assign phase_o    = phase_q;
    assign active_o   = active_q;
    assign boundary_o = !active_q || last;

endmodule

// File: rtl/clk_en_sched.sv
// Multi-channel clock-enable scheduler; a single outstanding config request is applied
// to its target channel only at that channel's period boundary.
module clk_en_sched
    import clk_sched_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    parameter  int unsigned DW  = 16,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic           cfg_done,
    output logic [NCH-1:0] ce,
    output logic [NCH-1:0] phase,
    output logic [NCH-1:0] active
);

    sched_state_t   state_q;
    sched_cfg_t     cfg_q;
    logic           done_q;
    logic [NCH-1:0] bnd;
    logic [NCH-1:0] load;
    logic           tgt_valid;
    logic           tgt_bnd;
    logic           apply;
    logic [DW-1:0]  div_eff;

    assign cfg_ready = (state_q == IDLE);
    assign cfg_done  = done_q;
    assign tgt_valid = (cfg_q.ch < SchedMaxChW'(NCH));
    assign div_eff   = (cfg_q.div == '0) ? {{(DW-1){1'b0}}, 1'b1} : cfg_q.div[DW-1:0];

    always_comb begin
        tgt_bnd = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            load[i] = (state_q == PEND) && (cfg_q.ch == SchedMaxChW'(i)) && bnd[i];
            tgt_bnd = tgt_bnd | load[i];
        end
        // Out-of-range targets complete immediately without touching any channel
        apply = tgt_bnd || ((state_q == PEND) && !tgt_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        cfg_q.ch  <= SchedMaxChW'(cfg_ch);
                        cfg_q.div <= SchedMaxDw'(cfg_div);
                        cfg_q.en  <= cfg_en;
                        state_q   <= PEND;
                    end
                end
                PEND: begin
                    if (apply) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_sched_chan #(
            .DW(DW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load[i]),
            .div_i     (div_eff),
            .en_i      (cfg_q.en),
            .ce_o      (ce[i]),
            .phase_o   (phase[i]),
            .active_o  (active[i]),
            .boundary_o(bnd[i])
        );
    end

endmodule

// File: tb/tb_clk_en_sched.sv
// Directed bench for clk_en_sched with five channels so that cfg_ch == NCH is encodable.
module tb_clk_en_sched;

    localparam int unsigned NCH = 5;
    localparam int unsigned DW  = 16;
    localparam int unsigned CHW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_en = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic           cfg_ready;
    logic           cfg_done;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] phase;
    logic [NCH-1:0] active;

    int checks = 0;
    int errors = 0;
    int n_ce0  = 0;
    int n_ph0  = 0;
    int n_ce1  = 0;
    bit cnt_on = 1'b0;

    always #5 clk = ~clk;

    clk_en_sched #(
        .NCH(NCH),
        .DW (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_en   (cfg_en),
        .cfg_done (cfg_done),
        .ce       (ce),
        .phase    (phase),
        .active   (active)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (cnt_on) begin
            n_ce0 += int'(ce[0]);
            n_ph0 += int'(phase[0]);
            n_ce1 += int'(ce[1]);
        end
    endtask

    task automatic req(input int ch, input int div, input bit en);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = DW'(div);
        cfg_en    = en;
    endtask

    initial begin
        // Reset held for three edges, then idle with no strobes
        repeat (3) step();
        rst = 1'b0;
        step();
        chk1("rst_ready", cfg_ready, 1'b1);
        chk1("rst_done", cfg_done, 1'b0);
        chkv("rst_ce", ce, '0);
        chkv("rst_phase", phase, '0);
        chkv("rst_active", active, '0);
        for (int k = 0; k < 20; k++) begin
            step();
            chkv("idle_ce", ce, '0);
        end

        // Enable ch0 div=4 from disabled
        req(0, 4, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk1("en0_pend_ready", cfg_ready, 1'b0);
        chk1("en0_pend_done", cfg_done, 1'b0);
        chkv("en0_pend_ce", ce, '0);
        step();
        chk1("en0_done", cfg_done, 1'b1);
        chk1("en0_ready", cfg_ready, 1'b1);
        chkv("en0_active", active, 5'b00001);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk1("div4_ce0", ce[0], (k % 4) == 0);
            chk1("div4_ph0", phase[0], (k % 4) < 2);
        end

        // Reprogram ch0 to div=3 while cnt=1; old period completes
        step();
        step();
        req(0, 3, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk1("rp0_c2_ready", cfg_ready, 1'b0);
        chk1("rp0_c2_ce0", ce[0], 1'b0);
        chk1("rp0_c2_ph0", phase[0], 1'b0);
        step();
        chk1("rp0_c3_done", cfg_done, 1'b0);
        chk1("rp0_c3_ce0", ce[0], 1'b0);
        step();
        chk1("rp0_done", cfg_done, 1'b1);
        chk1("rp0_new_ce0", ce[0], 1'b1);
        chk1("rp0_new_ph0", phase[0], 1'b1);
        for (int k = 1; k < 6; k++) begin
            step();
            chk1("div3_ce0", ce[0], (k % 3) == 0);
            chk1("div3_ph0", phase[0], (k % 3) < 2);
        end

        // ch1 div=4, then div=0 accepted in its last cycle: applies one period later
        req(1, 4, 1'b1);
        step();
        cfg_valid = 1'b0;
        step();
        chk1("en1_done", cfg_done, 1'b1);
        chk1("en1_ce1", ce[1], 1'b1);
        chkv("en1_active", active, 5'b00011);
        repeat (3) step();
        chk1("c3_ce1", ce[1], 1'b0);
        chk1("c3_ph1", phase[1], 1'b0);
        req(1, 0, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk1("late_c0_ce1", ce[1], 1'b1);
        chk1("late_c0_done", cfg_done, 1'b0);
        chk1("late_c0_ready", cfg_ready, 1'b0);
        step();
        chk1("late_c1_ce1", ce[1], 1'b0);
        chk1("late_c1_ph1", phase[1], 1'b1);
        step();
        chk1("late_c2_ph1", phase[1], 1'b0);
        step();
        chk1("late_c3_done", cfg_done, 1'b0);
        chk1("late_c3_ce1", ce[1], 1'b0);
        step();
        chk1("div0_done", cfg_done, 1'b1);
        chk1("div0_ce1", ce[1], 1'b1);
        chk1("div0_ph1", phase[1], 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("div1_ce1", ce[1], 1'b1);
            chk1("div1_ph1", phase[1], 1'b1);
        end

        // Back-to-back requests to ch2 (div=2) and ch3 (div=5)
        n_ce0  = 0;
        n_ph0  = 0;
        n_ce1  = 0;
        cnt_on = 1'b1;
        req(2, 2, 1'b1);
        step();
        chk1("b2b_held_ready", cfg_ready, 1'b0);
        req(3, 5, 1'b1);
        step();
        chk1("b2b_first_done", cfg_done, 1'b1);
        chk1("b2b_first_ready", cfg_ready, 1'b1);
        chk1("b2b_first_act2", active[2], 1'b1);
        chk1("b2b_first_ce2", ce[2], 1'b1);
        chk1("b2b_first_act3", active[3], 1'b0);
        step();
        cfg_valid = 1'b0;
        chk1("b2b_second_ready", cfg_ready, 1'b0);
        chk1("b2b_second_pend_done", cfg_done, 1'b0);
        chk1("div2_c1_ce2", ce[2], 1'b0);
        chk1("div2_c1_ph2", phase[2], 1'b0);
        step();
        chk1("b2b_second_done", cfg_done, 1'b1);
        chkv("b2b_active", active, 5'b01111);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            chk1("div5_ce3", ce[3], k == 0);
            chk1("div5_ph3", phase[3], k < 3);
            chk1("div2_ce2", ce[2], (k % 2) == 0);
        end
        repeat (4) step();
        cnt_on = 1'b0;
        chki("undisturbed_ce0", n_ce0, 4);
        chki("undisturbed_ph0", n_ph0, 8);
        chki("undisturbed_ce1", n_ce1, 12);

        // Reset while a request to ch0 is pending
        req(0, 8, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk1("rstp_pend_ready", cfg_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chkv("rstp_active_in_rst", active, '0);
        step();
        chk1("rstp_done", cfg_done, 1'b0);
        chk1("rstp_ready", cfg_ready, 1'b1);
        chkv("rstp_ce", ce, '0);
        chkv("rstp_phase", phase, '0);
        chkv("rstp_active", active, '0);
        step();
        chk1("rstp_no_late_done", cfg_done, 1'b0);
        chkv("rstp_still_idle", active, '0);

        // Out-of-range target completes with no channel change
        req(5, 7, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk1("oor_pend_ready", cfg_ready, 1'b0);
        step();
        chk1("oor_done", cfg_done, 1'b1);
        chk1("oor_ready", cfg_ready, 1'b1);
        chkv("oor_active", active, '0);
        chkv("oor_ce", ce, '0);
        step();
        chk1("oor_done_pulse", cfg_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
